store_narrow_unit: RTL

STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/store_narrow_unit_if.sv | 32 +++
 rtl/store_format.sv | 41 ++++
 rtl/store_narrow_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// mips_mem_pkg : store-size encodings, byte-enable constants, buffer entry type
// Revision     : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] SIZE_B    = 2'b00;
    localparam logic [1:0] SIZE_H    = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_narrow_unit_if.sv
`default_nettype none
// ============================================================================
// store_narrow_unit_if : core request and memory write channels of the unit
// Revision             : 1.0
// ============================================================================
interface store_narrow_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic [31:0] misalign_addr;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
               misalign, misalign_addr
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
               misalign, misalign_addr
    );
endinterface
`default_nettype wire

// File: rtl/store_format.sv
`default_nettype none
// ============================================================================
// store_format : lane replication, byte enables and misalign check for a store
// Revision     : 1.0
// ============================================================================
module store_format
    import mips_mem_pkg::*;
(
    input  logic [31:0]  addr_i,
    input  logic [31:0]  data_i,
    input  logic [1:0]   size_i,
    output store_entry_t entry_o,
    output logic         misalign_o
);

    always_comb begin
        entry_o.addr  = {addr_i[31:2], 2'b00};
        entry_o.wdata = data_i;
        entry_o.be    = BE_WORD;
        misalign_o    = 1'b0;
        case (size_i)
            SIZE_B: begin
                entry_o.wdata = {4{data_i[7:0]}};
                entry_o.be    = BE_BYTE << addr_i[1:0];
            end
            SIZE_H: begin
                entry_o.wdata = {2{data_i[15:0]}};
                entry_o.be    = addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign_o    = addr_i[0];
            end
            SIZE_W: begin
                misalign_o    = |addr_i[1:0];
            end
            default: begin
                misalign_o    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
// store_narrow_unit : buffers formatted narrow stores in a FIFO toward memory
// Revision          : 1.0
// ============================================================================
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    store_narrow_unit_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    store_entry_t   fmt_entry;
    logic           fmt_misalign;
    logic           accept;
    logic           push;
    logic           pop;

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           misalign_q, misalign_d;
    logic [31:0]    misalign_addr_q, misalign_addr_d;
    store_entry_t   fifo_q [DEPTH];
    store_entry_t   head;

    store_format u_format (
        .addr_i     (bus.req_addr),
        .data_i     (bus.req_data),
        .size_i     (bus.req_size),
        .entry_o    (fmt_entry),
        .misalign_o (fmt_misalign)
    );

    // Ready depends only on the registered count, so a same-cycle pop cannot unblock a full buffer.
    assign bus.req_ready = (count_q < CW'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && !fmt_misalign;
    assign pop           = bus.mem_valid && bus.mem_ready;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        misalign_d      = accept && fmt_misalign;
        misalign_addr_d = misalign_addr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (accept && fmt_misalign) begin
            misalign_addr_d = bus.req_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // Entry storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= fmt_entry;
        end
    end

    assign head              = fifo_q[rd_ptr_q];
    assign bus.mem_valid     = (count_q != '0);
    assign bus.mem_addr      = bus.mem_valid ? head.addr  : '0;
    assign bus.mem_wdata     = bus.mem_valid ? head.wdata : '0;
    assign bus.mem_be        = bus.mem_valid ? head.be    : '0;
    assign bus.misalign      = misalign_q;
    assign bus.misalign_addr = misalign_addr_q;

endmodule
`default_nettype wire
